// File: rtl/mc_sched_pkg.sv
// rtl/mc_sched_pkg.sv - frame layout, lock state type and shared helpers for mc_frame_sched
package mc_sched_pkg;

    localparam int CMD_WIDTH = 3;
    localparam int CMD_LAST  = 2;
    localparam int CMD_WRITE = 1;
    localparam int CMD_READ  = 0;

    typedef enum logic {
        LK_IDLE = 1'b0,
        LK_LOCK = 1'b1
    } lock_state_t;

    // Minimum result of 1 so single-entry ranges still get a usable width.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int frame_width(input int row_w, input int col_w, input int data_w);
        return CMD_WIDTH + row_w + col_w + data_w;
    endfunction

    function automatic int row_lsb(input int col_w, input int data_w);
        return col_w + data_w;
    endfunction

    function automatic int cmd_lsb(input int row_w, input int col_w, input int data_w);
        return row_w + col_w + data_w;
    endfunction

    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mc_sched_fifo.sv
// rtl/mc_sched_fifo.sv - per-channel synchronous FIFO with registered full/empty and head data
module mc_sched_fifo
    import mc_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr[AW-1:0]];

    // Next pointers; the extra MSB distinguishes full from empty on wrap.
    always_comb begin
        wr_ptr_nxt = do_push ? wr_ptr + (AW+1)'(1) : wr_ptr;
        rd_ptr_nxt = do_pop  ? rd_ptr + (AW+1)'(1) : rd_ptr;
    end

    // Pointers and flags are registered from the next-pointer values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/mc_frame_sched.sv
// rtl/mc_frame_sched.sv - multi-channel frame scheduler with burst lock and row-hit arbitration
module mc_frame_sched
    import mc_sched_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int FIFO_DEPTH       = 4,
    parameter int ARRAY_ROW_ADDR   = 14,
    parameter int ARRAY_COL_ADDR   = 6,
    parameter int ARRAY_DATA_WIDTH = 64,
    parameter int FRAME_DATA_WIDTH = frame_width(ARRAY_ROW_ADDR, ARRAY_COL_ADDR, ARRAY_DATA_WIDTH),
    parameter int MAX_HIT          = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_CH-1:0]                  in_valid,
    output logic [NUM_CH-1:0]                  in_ready,
    input  logic [NUM_CH*FRAME_DATA_WIDTH-1:0] in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FRAME_DATA_WIDTH-1:0]        out_data,
    output logic [clog2(NUM_CH)-1:0]           out_ch,
    input  logic                               sched_mode,
    output logic [NUM_CH-1:0]                  ch_full
);

    localparam int FW      = FRAME_DATA_WIDTH;
    localparam int CH_W    = clog2(NUM_CH);
    localparam int HIT_W   = clog2(MAX_HIT + 1);
    localparam int ROW_LSB = row_lsb(ARRAY_COL_ADDR, ARRAY_DATA_WIDTH);
    localparam int CMD_LSB = cmd_lsb(ARRAY_ROW_ADDR, ARRAY_COL_ADDR, ARRAY_DATA_WIDTH);

    lock_state_t               state, state_nxt;
    logic [CH_W-1:0]           lock_ch, lock_ch_nxt;
    logic [CH_W-1:0]           rr_ptr, rr_ptr_nxt;
    logic [HIT_W-1:0]          hit_cnt, hit_cnt_nxt, sel_hit_cnt;
    logic [ARRAY_ROW_ADDR-1:0] last_row;
    logic                      last_row_vld;

    logic [NUM_CH-1:0]         fifo_empty;
    logic [NUM_CH-1:0]         fifo_pop;
    logic [FW-1:0]             head_data [NUM_CH];
    logic [NUM_CH-1:0]         cand;

    logic                      rr_found, hit_found;
    logic [CH_W-1:0]           rr_win, hit_win;
    int                        scan_idx;

    logic                      load, grant_vld, do_grant, grant_last;
    logic [CH_W-1:0]           grant_ch;
    logic [FW-1:0]             grant_frame;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic fifo_full;

        mc_sched_fifo #(
            .WIDTH (FW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (in_valid[i]),
            .push_data (in_data[i*FW +: FW]),
            .pop       (fifo_pop[i]),
            .head_data (head_data[i]),
            .full      (fifo_full),
            .empty     (fifo_empty[i])
        );

        assign in_ready[i] = ~fifo_full;
        assign ch_full[i]  = fifo_full;
    end

    assign cand = ~fifo_empty;
    assign load = !out_valid || out_ready;

    // Scan from rr_ptr for the first candidate and the first row-hit candidate.
    always_comb begin
        rr_found  = 1'b0;
        rr_win    = '0;
        hit_found = 1'b0;
        hit_win   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = wrap_idx(int'(rr_ptr), k, NUM_CH);
            if (!rr_found && cand[scan_idx]) begin
                rr_found = 1'b1;
                rr_win   = CH_W'(scan_idx);
            end
            if (!hit_found && cand[scan_idx] && last_row_vld &&
                (head_data[scan_idx][CMD_LSB-1:ROW_LSB] == last_row)) begin
                hit_found = 1'b1;
                hit_win   = CH_W'(scan_idx);
            end
        end
    end

    // Grant selection, lock FSM, hit counter and rr pointer next state.
    always_comb begin
        state_nxt   = state;
        lock_ch_nxt = lock_ch;
        rr_ptr_nxt  = rr_ptr;
        hit_cnt_nxt = hit_cnt;
        sel_hit_cnt = '0;
        grant_vld   = 1'b0;
        grant_ch    = rr_win;
        fifo_pop    = '0;

        if (state == LK_LOCK) begin
            grant_vld = cand[lock_ch];
            grant_ch  = lock_ch;
        end else begin
            grant_vld = rr_found;
            // Once the cap is reached the round-robin choice wins and the count restarts.
            if (sched_mode && hit_found && (hit_cnt != HIT_W'(MAX_HIT))) begin
                grant_ch    = hit_win;
                sel_hit_cnt = (hit_win != rr_win) ? hit_cnt + HIT_W'(1) : '0;
            end
        end

        grant_frame = head_data[grant_ch];
        grant_last  = grant_frame[CMD_LSB + CMD_LAST];
        do_grant    = load && grant_vld;

        if (do_grant) begin
            fifo_pop[grant_ch] = 1'b1;
            if (state == LK_IDLE) begin
                hit_cnt_nxt = sel_hit_cnt;
            end
            if (grant_last) begin
                state_nxt  = LK_IDLE;
                rr_ptr_nxt = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
            end else begin
                state_nxt   = LK_LOCK;
                lock_ch_nxt = grant_ch;
            end
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LK_IDLE;
            lock_ch <= '0;
            rr_ptr  <= '0;
            hit_cnt <= '0;
        end else begin
            state   <= state_nxt;
            lock_ch <= lock_ch_nxt;
            rr_ptr  <= rr_ptr_nxt;
            hit_cnt <= hit_cnt_nxt;
        end
    end

    // Output stage and row tracking; the stage holds while stalled by out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_ch       <= '0;
            last_row     <= '0;
            last_row_vld <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= do_grant;
            end
            if (do_grant) begin
                out_data     <= grant_frame;
                out_ch       <= grant_ch;
                last_row     <= grant_frame[CMD_LSB-1:ROW_LSB];
                last_row_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mc_frame_sched.sv
// tb/tb_mc_frame_sched.sv - scoreboard testbench for mc_frame_sched
module tb_mc_frame_sched;

    localparam int FW = 3 + 14 + 6 + 64;

    typedef struct {
        logic [0:0]    ch;
        logic [FW-1:0] f;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [1:0]      in_valid;
    logic [1:0]      in_ready;
    logic [2*FW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [FW-1:0]   out_data;
    logic [0:0]      out_ch;
    logic            sched_mode;
    logic [1:0]      ch_full;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    mc_frame_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ch     (out_ch),
        .sched_mode (sched_mode),
        .ch_full    (ch_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] mk(input logic [2:0] cmd, input logic [13:0] row,
                                         input logic [63:0] data);
        return {cmd, row, 6'd0, data};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_f(input logic [0:0] ch, input logic [FW-1:0] f);
        exp_t e;
        e.ch = ch;
        e.f  = f;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input int ch, input logic [FW-1:0] f);
        int n;
        bit ok;
        n = 0;
        in_valid[ch]         = 1'b1;
        in_data[ch*FW +: FW] = f;
        do begin
            ok = in_ready[ch];
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: ch%0d not accepted after %0d cycles, expected accept", ch, n);
        end
        in_valid[ch] = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d frames outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        cycles(1);
    endtask

    // Monitor: every accepted output frame is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got ch%0d data %0h, expected no frame", out_ch, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_ch !== e.ch || out_data !== e.f) begin
                    errors++;
                    $display("FAIL out_frame: got ch%0d data %0h, expected ch%0d data %0h",
                             out_ch, out_data, e.ch, e.f);
                end
            end
        end
    end

    initial begin
        in_valid   = '0;
        in_data    = '0;
        out_ready  = 1'b0;
        sched_mode = 1'b0;
        rst_n      = 1'b0;
        cycles(2);

        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data",  128'(out_data),  128'(0));
        chk("rst_out_ch",    128'(out_ch),    128'(0));
        chk("rst_in_ready",  128'(in_ready),  128'(3));
        chk("rst_ch_full",   128'(ch_full),   128'(0));
        rst_n = 1'b1;
        cycles(1);

        // Single three-frame burst from ch0, round-robin mode.
        out_ready = 1'b1;
        expect_f(1'b0, mk(3'd0, 14'h0001, 64'hA0));
        expect_f(1'b0, mk(3'd0, 14'h0001, 64'hA1));
        expect_f(1'b0, mk(3'd4, 14'h0001, 64'hA2));
        push(0, mk(3'd0, 14'h0001, 64'hA0));
        chk("latency_edge_n", 128'(out_valid), 128'(0));
        push(0, mk(3'd0, 14'h0001, 64'hA1));
        chk("latency_edge_n1", 128'(out_valid), 128'(1));
        push(0, mk(3'd4, 14'h0001, 64'hA2));
        wait_drain();
        chk("rr_ptr_after_burst", 128'(dut.rr_ptr), 128'(1));

        // Burst atomicity: ch0 burst with a gap, ch1 queued meanwhile.
        out_ready = 1'b0;
        expect_f(1'b0, mk(3'd0, 14'h0002, 64'hD0));
        expect_f(1'b0, mk(3'd0, 14'h0002, 64'hD1));
        expect_f(1'b0, mk(3'd0, 14'h0002, 64'hD2));
        expect_f(1'b0, mk(3'd4, 14'h0002, 64'hD3));
        expect_f(1'b1, mk(3'd4, 14'h0003, 64'hE0));
        expect_f(1'b1, mk(3'd4, 14'h0003, 64'hE1));
        push(0, mk(3'd0, 14'h0002, 64'hD0));
        push(0, mk(3'd0, 14'h0002, 64'hD1));
        push(1, mk(3'd4, 14'h0003, 64'hE0));
        push(1, mk(3'd4, 14'h0003, 64'hE1));
        out_ready = 1'b1;
        cycles(3);
        chk("atomic_stall_valid", 128'(out_valid), 128'(0));
        push(0, mk(3'd0, 14'h0002, 64'hD2));
        push(0, mk(3'd4, 14'h0002, 64'hD3));
        wait_drain();

        // Round-robin fairness across four single-frame bursts per channel.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_f(1'b0, mk(3'd4, 14'h0040, 64'h100 + 64'(i)));
            expect_f(1'b1, mk(3'd4, 14'h0030, 64'h200 + 64'(i)));
        end
        for (int i = 0; i < 4; i++) push(0, mk(3'd4, 14'h0040, 64'h100 + 64'(i)));
        for (int i = 0; i < 4; i++) push(1, mk(3'd4, 14'h0030, 64'h200 + 64'(i)));
        out_ready = 1'b1;
        wait_drain();

        // Row-hit mode with the consecutive-hit cap.
        sched_mode = 1'b1;
        out_ready  = 1'b0;
        for (int i = 0; i < 5; i++) expect_f(1'b0, mk(3'd4, 14'h0010, 64'h300 + 64'(i)));
        expect_f(1'b1, mk(3'd4, 14'h0020, 64'h400));
        expect_f(1'b0, mk(3'd4, 14'h0010, 64'h305));
        for (int i = 0; i < 5; i++) push(0, mk(3'd4, 14'h0010, 64'h300 + 64'(i)));
        push(1, mk(3'd4, 14'h0020, 64'h400));
        out_ready = 1'b1;
        push(0, mk(3'd4, 14'h0010, 64'h305));
        wait_drain();

        // Backpressure until ch1's FIFO fills, then release.
        sched_mode = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < 6; i++) expect_f(1'b1, mk(3'd4, 14'h0005, 64'h500 + 64'(i)));
        push(1, mk(3'd4, 14'h0005, 64'h500));
        push(1, mk(3'd4, 14'h0005, 64'h501));
        chk("bp_valid_after_push", 128'(out_valid), 128'(1));
        for (int i = 2; i < 5; i++) push(1, mk(3'd4, 14'h0005, 64'h500 + 64'(i)));
        chk("bp_full_in_ready",  128'(in_ready[1]), 128'(0));
        chk("bp_full_ch_full",   128'(ch_full[1]),  128'(1));
        chk("bp_other_in_ready", 128'(in_ready[0]), 128'(1));
        cycles(1);
        chk("bp_hold_data", 128'(out_data), 128'(mk(3'd4, 14'h0005, 64'h500)));
        chk("bp_hold_ch",   128'(out_ch),   128'(1));
        chk("bp_hold_ready", 128'(in_ready[1]), 128'(0));
        out_ready = 1'b1;
        cycles(1);
        chk("bp_ready_rise", 128'(in_ready[1]), 128'(1));
        chk("bp_full_clear", 128'(ch_full[1]),  128'(0));
        push(1, mk(3'd4, 14'h0005, 64'h505));
        wait_drain();

        // Reset in the middle of a ch0 burst.
        out_ready = 1'b0;
        push(0, mk(3'd0, 14'h0006, 64'h600));
        push(0, mk(3'd0, 14'h0006, 64'h601));
        chk("pre_rst_valid", 128'(out_valid), 128'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 128'(out_valid), 128'(0));
        exp_q.delete();
        cycles(1);
        chk("rst_mid_in_ready", 128'(in_ready), 128'(3));
        chk("rst_mid_out_data", 128'(out_data), 128'(0));
        rst_n = 1'b1;
        cycles(1);
        chk("post_rst_in_ready", 128'(in_ready), 128'(3));
        chk("post_rst_ch_full",  128'(ch_full),  128'(0));
        out_ready = 1'b1;
        expect_f(1'b1, mk(3'd4, 14'h0007, 64'h700));
        push(1, mk(3'd4, 14'h0007, 64'h700));
        wait_drain();
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_frame_sched.md
# mc_frame_sched

Multi-channel frame scheduler for the memory controller. It replaces the single fixed two-entry frame buffer between the AXI slave and `array_ctrl`. It accepts frames from `NUM_CH` requesters, buffers each in its own FIFO, and issues one frame per cycle to `array_ctrl`. Burst atomicity is preserved, and issue order is either round-robin or row-hit-first with a starvation cap.

## Interface
- `NUM_CH`, 2: requester channels (≥2).
- `FIFO_DEPTH`, 4: entries per channel FIFO (power of 2, ≥2).
- `ARRAY_ROW_ADDR`, 14: row field width.
- `ARRAY_COL_ADDR`, 6: column field width.
- `ARRAY_DATA_WIDTH`, 64: data field width.
- `FRAME_DATA_WIDTH`, 3+ROW+COL+DATA: frame width.
- `MAX_HIT`, 4: maximum consecutive row-hit grants that bypass the round-robin choice.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in NUM_CH: per-channel frame valid.
- `in_ready` out NUM_CH: per-channel ready; equals not-full.
- `in_data` in NUM_CH*FRAME_DATA_WIDTH: channel i occupies slice `[i*FW +: FW]`.
- `out_valid` out 1: frame to `array_ctrl` is valid.
- `out_ready` in 1: `array_ctrl` accepts the frame.
- `out_data` out FRAME_DATA_WIDTH: issued frame.
- `out_ch` out clog2(NUM_CH): source channel of `out_data`.
- `sched_mode` in 1: 0 = round-robin, 1 = row-hit-first.
- `ch_full` out NUM_CH: per-channel FIFO full status.

## Operation
- Frame layout, MSB first: `cmd[2:0]`, row, col, data.
  - `cmd[2]` = last frame of burst.
  - `cmd[1]` = write.
  - `cmd[0]` = read.
- Push: `in_valid[i] & in_ready[i]` at a clock edge writes the frame to FIFO i. FIFO order is preserved within each channel.
- Output stage is a single register. It loads when empty, or when `out_valid & out_ready` in the same cycle.
- Arbitration runs only when the output stage loads. Candidates are the channels with a non-empty FIFO head.
- States:
  - IDLE (unlocked): any candidate may win.
  - LOCK(ch): only `ch` is eligible. If FIFO `ch` is empty, the output stalls and no other channel is granted.
- Transitions:
  - IDLE → LOCK(ch) when the grant's frame has `cmd[2]`=0.
  - LOCK(ch) → IDLE when the issued frame from `ch` has `cmd[2]`=1.
  - A grant with `cmd[2]`=1 in IDLE stays in IDLE.
- `rr_ptr`: highest-priority channel. On every burst-ending grant (`cmd[2]`=1) from channel g, `rr_ptr` ← (g+1) mod NUM_CH.
- Round-robin winner: the first candidate at or after `rr_ptr`, with wrap.
- Row-hit mode:
  - Tracking: `last_row`/`last_row_vld` are updated on every load. `last_row_vld` is 0 after reset.
  - A hit is a candidate whose head row equals `last_row` while `last_row_vld`=1.
  - In IDLE with a hit present, the winner is the first hit scanning from `rr_ptr`.
  - `hit_cnt` increments when the hit winner differs from the round-robin winner. It clears otherwise.
  - When `hit_cnt`=MAX_HIT, the round-robin winner is forced and `hit_cnt` clears.
- `sched_mode` is sampled only in IDLE. A change mid-burst takes effect at the next IDLE arbitration.
- `out_ch` and `out_data` hold stable while `out_valid & !out_ready`.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ch`=0.
  - `in_ready`=all 1, `ch_full`=0.
  - State IDLE, `rr_ptr`=0, `hit_cnt`=0, `last_row_vld`=0.
- Latency: a frame pushed at edge N is visible on `out_valid` from edge N+1 at the earliest. That is, `out_valid` rises in the cycle after the push, when the output stage is free.
- Throughput: 1 frame/cycle sustained with `out_ready`=1.
- `in_ready[i]` and `ch_full[i]` are registered.
  - When FIFO i is full, `in_ready[i]`=0; there is no same-cycle pop-to-push pass-through.
  - They rise the cycle after a pop from the full FIFO.
- Same-cycle push to a non-full FIFO while it is popped: both take effect and the count is unchanged.
- FIFO pointers are clog2(FIFO_DEPTH)+1 bits with natural wrap. Full = MSBs differ and low bits equal.
- Reset asserted mid-burst: all FIFOs empty, lock drops, any pending output is discarded.

## Structure
- Package `mc_sched_pkg` holds:
  - Frame field offsets and `cmd` bit indices.
  - `FRAME_DATA_WIDTH` derivation.
  - A clog2 function, shared with `array_ctrl` frame decode.
- Sub-module `mc_sched_fifo`: synchronous FIFO with registered full/empty and exposed head data, instantiated NUM_CH times.
- Arbiter, lock FSM, hit counter and output register live in the top level.

## Test plan
- Single burst, RR mode: ch0 pushes 3 frames with `cmd[2]` = 0,0,1, `out_ready`=1.
  - Expect `out_valid` at N+1, then 3 consecutive frames with `out_ch`=0.
  - Expect `rr_ptr`=1 afterward.
- Burst atomicity: ch0 sends a 4-frame burst with a 2-cycle gap after frame 2; ch1 has frames queued throughout.
  - Expect the output to stall during the gap with no ch1 frame interleaved.
  - Expect ch1 to be granted right after ch0's last frame.
- RR fairness: both channels hold 4 single-frame bursts.
  - Expect `out_ch` sequence 0,1,0,1,0,1,0,1.
- Row-hit with cap, `sched_mode`=1, MAX_HIT=4:
  - ch0 holds 6 single frames at row 0x0010; ch1 holds frames at row 0x0020; the first issue is ch0.
  - Expect ch0 ×5 (the first issue plus 4 hits), then ch1 forced, then ch0.
- Backpressure/full, FIFO_DEPTH=4: `out_ready`=0, ch1 pushes 6 frames.
  - Expect `out_valid`=1 after the first push; after the 5th accepted push, ch1's FIFO is full.
  - Expect `in_ready[1]`=0 and `ch_full[1]`=1, with `out_data` stable.
  - When `out_ready` goes to 1, `in_ready[1]` rises one cycle after the first pop.
- Reset mid-burst: assert `rst_n`=0 after 2 of 4 frames.
  - Expect `out_valid`=0 asynchronously and `in_ready`=all 1 after release.
  - A new ch1 frame issues without lock.
